// File: rtl/prog_mem_loader_if.sv
// Bundle of the boot-stream, cpu memory port and dump-stream signals of prog_mem_loader.
// state_o mirrors the loader FSM so checkers can bind to it without reaching into the block.
interface prog_mem_loader_if #(
   parameter int ADDR_WIDTH = 8
);
   logic [7:0]            load_data_i;
   logic                  load_valid_i;
   logic                  load_last_i;
   logic                  load_ready_o;
   logic                  cpu_rst_o;
   logic [ADDR_WIDTH-1:0] mem_addr_i;
   logic [15:0]           mem_value_i;
   logic                  mem_enable_i;
   logic                  mem_wr_en_i;
   logic                  mem_rd_en_i;
   logic [15:0]           mem_value_o;
   logic                  end_program_i;
   logic [7:0]            dump_data_o;
   logic                  dump_valid_o;
   logic                  dump_ready_i;
   logic                  done_o;
   logic [1:0]            state_o;

   modport slave (
      input  load_data_i, load_valid_i, load_last_i,
      input  mem_addr_i, mem_value_i, mem_enable_i, mem_wr_en_i, mem_rd_en_i,
      input  end_program_i, dump_ready_i,
      output load_ready_o, cpu_rst_o, mem_value_o,
      output dump_data_o, dump_valid_o, done_o, state_o
   );

   modport master (
      output load_data_i, load_valid_i, load_last_i,
      output mem_addr_i, mem_value_i, mem_enable_i, mem_wr_en_i, mem_rd_en_i,
      output end_program_i, dump_ready_i,
      input  load_ready_o, cpu_rst_o, mem_value_o,
      input  dump_data_o, dump_valid_o, done_o, state_o
   );
endinterface

// File: rtl/prog_mem_loader.sv
// Unified 16-bit program/data memory: boots from a byte stream, serves the cpu port,
// then streams words 0..DUMP_WORDS-1 back out as bytes when the program ends.
module prog_mem_loader #(
   parameter int ADDR_WIDTH = 8,
   parameter int DUMP_WORDS = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   prog_mem_loader_if.slave    bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   localparam logic [1:0] S_LOAD = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DUMP = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DUMP_WORDS - 1);

   logic [15:0] mem [DEPTH];

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] load_addr_q, load_addr_d;
   logic                  phase_q, phase_d;
   logic [7:0]            low_byte_q, low_byte_d;
   logic                  cpu_rst_q, cpu_rst_d;
   logic [15:0]           rd_data_q, rd_data_d;
   logic [15:0]           dump_word_q, dump_word_d;
   logic [ADDR_WIDTH-1:0] dump_ptr_q, dump_ptr_d;
   logic                  dump_hi_q, dump_hi_d;
   logic                  dump_valid_q, dump_valid_d;

   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [15:0]           mem_wdata;
   logic [ADDR_WIDTH-1:0] next_ptr;

   // Both streams use valid/ready: a byte moves on a rising edge where valid and ready are
   // both high; the producer keeps valid and data stable until that edge.
   always_comb begin
      state_d      = state_q;
      load_addr_d  = load_addr_q;
      phase_d      = phase_q;
      low_byte_d   = low_byte_q;
      rd_data_d    = rd_data_q;
      dump_word_d  = dump_word_q;
      dump_ptr_d   = dump_ptr_q;
      dump_hi_d    = dump_hi_q;
      dump_valid_d = dump_valid_q;
      mem_we       = 1'b0;
      mem_waddr    = load_addr_q;
      mem_wdata    = {8'h00, bus.load_data_i};
      next_ptr     = dump_ptr_q + 1'b1;

      case (state_q)
         S_LOAD: begin
            if (bus.load_valid_i) begin
               if (!phase_q) begin
                  if (bus.load_last_i) begin
                     mem_we  = 1'b1;
                     state_d = S_RUN;
                  end else begin
                     low_byte_d = bus.load_data_i;
                     phase_d    = 1'b1;
                  end
               end else begin
                  mem_we    = 1'b1;
                  mem_wdata = {bus.load_data_i, low_byte_q};
                  phase_d   = 1'b0;
                  if (bus.load_last_i || load_addr_q == ADDR_MAX) state_d = S_RUN;
                  else load_addr_d = load_addr_q + 1'b1;
               end
               if (state_d == S_RUN) begin
                  load_addr_d = '0;
                  phase_d     = 1'b0;
               end
            end
         end
         S_RUN: begin
            // The read samples the array before this edge's write lands: read-before-write.
            if (bus.mem_enable_i && bus.mem_wr_en_i) begin
               mem_we    = 1'b1;
               mem_waddr = bus.mem_addr_i;
               mem_wdata = bus.mem_value_i;
            end
            if (bus.mem_enable_i && bus.mem_rd_en_i) rd_data_d = mem[bus.mem_addr_i];
            if (bus.end_program_i) begin
               state_d      = S_DUMP;
               dump_ptr_d   = '0;
               dump_hi_d    = 1'b0;
               dump_valid_d = 1'b0;
            end
         end
         S_DUMP: begin
            if (!dump_valid_q) begin
               dump_word_d  = mem[dump_ptr_q];
               dump_valid_d = 1'b1;
            end else if (bus.dump_ready_i) begin
               if (!dump_hi_q) begin
                  dump_hi_d = 1'b1;
               end else if (dump_ptr_q == LAST_WORD) begin
                  state_d      = S_DONE;
                  dump_valid_d = 1'b0;
                  dump_hi_d    = 1'b0;
                  dump_word_d  = '0;
               end else begin
                  // Fetch the next word while its low byte is being presented.
                  dump_ptr_d  = next_ptr;
                  dump_hi_d   = 1'b0;
                  dump_word_d = mem[next_ptr];
               end
            end
         end
         default: ;
      endcase

      cpu_rst_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= S_LOAD;
         load_addr_q  <= '0;
         phase_q      <= 1'b0;
         low_byte_q   <= '0;
         cpu_rst_q    <= 1'b0;
         rd_data_q    <= '0;
         dump_word_q  <= '0;
         dump_ptr_q   <= '0;
         dump_hi_q    <= 1'b0;
         dump_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         load_addr_q  <= load_addr_d;
         phase_q      <= phase_d;
         low_byte_q   <= low_byte_d;
         cpu_rst_q    <= cpu_rst_d;
         rd_data_q    <= rd_data_d;
         dump_word_q  <= dump_word_d;
         dump_ptr_q   <= dump_ptr_d;
         dump_hi_q    <= dump_hi_d;
         dump_valid_q <= dump_valid_d;
      end
   end

   // Contents survive reset; the next boot overwrites them.
   always_ff @(posedge clk_i) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   assign bus.load_ready_o = (state_q == S_LOAD);
   assign bus.cpu_rst_o    = cpu_rst_q;
   assign bus.mem_value_o  = rd_data_q;
   assign bus.dump_valid_o = dump_valid_q;
   assign bus.dump_data_o  = dump_hi_q ? dump_word_q[15:8] : dump_word_q[7:0];
   assign bus.done_o       = (state_q == S_DONE);
   assign bus.state_o      = state_q;
endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: boot, cpu access, dump with back-pressure, resets.
// dut_a: ADDR_WIDTH=8, DUMP_WORDS=2; dut_b: ADDR_WIDTH=2, DUMP_WORDS=4 for the full-memory boot.
module tb_prog_mem_loader;
   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [7:0] exp_q[$];

   prog_mem_loader_if #(.ADDR_WIDTH(8)) bus_a ();
   prog_mem_loader_if #(.ADDR_WIDTH(2)) bus_b ();

   prog_mem_loader #(.ADDR_WIDTH(8), .DUMP_WORDS(2)) dut_a (
      .clk_i(clk), .rst_i(rst_a), .bus(bus_a.slave));
   prog_mem_loader #(.ADDR_WIDTH(2), .DUMP_WORDS(4)) dut_b (
      .clk_i(clk), .rst_i(rst_b), .bus(bus_b.slave));

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic load_byte(input bit sel, input logic [7:0] data, input logic last);
      if (sel) begin
         bus_b.load_valid_i = 1'b1; bus_b.load_data_i = data; bus_b.load_last_i = last;
      end else begin
         bus_a.load_valid_i = 1'b1; bus_a.load_data_i = data; bus_a.load_last_i = last;
      end
      @(negedge clk);
      bus_a.load_valid_i = 1'b0; bus_a.load_last_i = 1'b0;
      bus_b.load_valid_i = 1'b0; bus_b.load_last_i = 1'b0;
   endtask

   task automatic cpu_cycle(input bit sel, input logic en, input logic wr, input logic rd,
                            input logic [7:0] addr, input logic [15:0] val, input logic endp);
      if (sel) begin
         bus_b.mem_enable_i = en; bus_b.mem_wr_en_i = wr; bus_b.mem_rd_en_i = rd;
         bus_b.mem_addr_i = addr[1:0]; bus_b.mem_value_i = val; bus_b.end_program_i = endp;
      end else begin
         bus_a.mem_enable_i = en; bus_a.mem_wr_en_i = wr; bus_a.mem_rd_en_i = rd;
         bus_a.mem_addr_i = addr; bus_a.mem_value_i = val; bus_a.end_program_i = endp;
      end
      @(negedge clk);
   endtask

   initial begin
      bit         pat [6];
      int         pi, waits, cyc, acc;
      bit         held, started;
      logic [7:0] hb;
      pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

      rst_a = 1'b0; rst_b = 1'b0;
      bus_a.load_data_i = '0; bus_a.load_valid_i = 1'b0; bus_a.load_last_i = 1'b0;
      bus_a.mem_addr_i = '0; bus_a.mem_value_i = '0; bus_a.mem_enable_i = 1'b0;
      bus_a.mem_wr_en_i = 1'b0; bus_a.mem_rd_en_i = 1'b0; bus_a.end_program_i = 1'b0;
      bus_a.dump_ready_i = 1'b0;
      bus_b.load_data_i = '0; bus_b.load_valid_i = 1'b0; bus_b.load_last_i = 1'b0;
      bus_b.mem_addr_i = '0; bus_b.mem_value_i = '0; bus_b.mem_enable_i = 1'b0;
      bus_b.mem_wr_en_i = 1'b0; bus_b.mem_rd_en_i = 1'b0; bus_b.end_program_i = 1'b0;
      bus_b.dump_ready_i = 1'b0;
      #1;
      check("rst_state", bus_a.state_o, 0);
      check("rst_load_ready", bus_a.load_ready_o, 1);
      check("rst_cpu_rst", bus_a.cpu_rst_o, 0);
      check("rst_mem_value", bus_a.mem_value_o, 0);
      check("rst_dump_valid", bus_a.dump_valid_o, 0);
      check("rst_dump_data", bus_a.dump_data_o, 0);
      check("rst_done", bus_a.done_o, 0);
      @(negedge clk);
      rst_a = 1'b1; rst_b = 1'b1;

      // even-length boot
      load_byte(0, 8'h34, 0);
      load_byte(0, 8'h12, 0);
      load_byte(0, 8'h78, 0);
      check("cpu_rst_before_last", bus_a.cpu_rst_o, 0);
      check("load_ready_before_last", bus_a.load_ready_o, 1);
      load_byte(0, 8'h56, 1);
      check("cpu_rst_after_last", bus_a.cpu_rst_o, 1);
      check("load_ready_after_last", bus_a.load_ready_o, 0);
      check("state_run", bus_a.state_o, 1);
      cpu_cycle(0, 1, 0, 1, 8'd0, 16'h0, 0);
      check("rd_mem0", bus_a.mem_value_o, 16'h1234);
      cpu_cycle(0, 1, 0, 1, 8'd1, 16'h0, 0);
      check("rd_mem1", bus_a.mem_value_o, 16'h5678);

      // cpu port
      cpu_cycle(0, 1, 1, 0, 8'd5, 16'hBEEF, 0);
      cpu_cycle(0, 1, 0, 1, 8'd5, 16'h0, 0);
      check("rd_after_wr", bus_a.mem_value_o, 16'hBEEF);
      cpu_cycle(0, 1, 1, 1, 8'd5, 16'h1111, 0);
      check("rbw_old", bus_a.mem_value_o, 16'hBEEF);
      cpu_cycle(0, 1, 0, 1, 8'd5, 16'h0, 0);
      check("rbw_new", bus_a.mem_value_o, 16'h1111);
      cpu_cycle(0, 0, 1, 1, 8'd5, 16'h2222, 0);
      check("no_enable_hold", bus_a.mem_value_o, 16'h1111);
      cpu_cycle(0, 1, 0, 1, 8'd5, 16'h0, 0);
      check("no_enable_write", bus_a.mem_value_o, 16'h1111);
      cpu_cycle(0, 0, 0, 0, 8'd0, 16'h0, 0);
      check("idle_hold", bus_a.mem_value_o, 16'h1111);

      // dump with back-pressure
      cpu_cycle(0, 0, 0, 0, 8'd0, 16'h0, 1);
      bus_a.end_program_i = 1'b0;
      check("state_dump", bus_a.state_o, 2);
      check("dump_cpu_rst", bus_a.cpu_rst_o, 0);
      exp_q.push_back(8'h34); exp_q.push_back(8'h12);
      exp_q.push_back(8'h78); exp_q.push_back(8'h56);
      pi = 0; held = 0; waits = 0; cyc = 0; hb = '0;
      while (exp_q.size() > 0 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (held) begin
            check("dump_stall_valid", bus_a.dump_valid_o, 1);
            check("dump_stall_data", bus_a.dump_data_o, hb);
         end
         if (!bus_a.dump_valid_o) begin
            waits++;
            bus_a.dump_ready_i = 1'b0;
            held = 0;
         end else begin
            bus_a.dump_ready_i = pat[pi % 6];
            pi++;
            if (bus_a.dump_ready_i) begin
               check("dump_byte", bus_a.dump_data_o, exp_q.pop_front());
               held = 0;
            end else begin
               held = 1;
               hb = bus_a.dump_data_o;
            end
         end
      end
      check("dump_drained", exp_q.size(), 0);
      check("dump_first_latency", 32'(waits <= 1), 1);
      exp_q.delete();
      @(negedge clk);
      bus_a.dump_ready_i = 1'b0;
      check("done", bus_a.done_o, 1);
      check("done_valid", bus_a.dump_valid_o, 0);
      check("done_cpu_rst", bus_a.cpu_rst_o, 0);
      bus_a.load_valid_i = 1'b1; bus_a.end_program_i = 1'b1;
      @(negedge clk);
      bus_a.load_valid_i = 1'b0; bus_a.end_program_i = 1'b0;
      check("done_sticky", bus_a.state_o, 3);
      check("done_load_ready", bus_a.load_ready_o, 0);

      // odd-length boot after reset
      rst_a = 1'b0;
      @(negedge clk);
      rst_a = 1'b1;
      load_byte(0, 8'hAB, 1);
      check("odd_state_run", bus_a.state_o, 1);
      cpu_cycle(0, 1, 0, 1, 8'd0, 16'h0, 0);
      check("odd_mem0", bus_a.mem_value_o, 16'h00AB);
      cpu_cycle(0, 1, 0, 1, 8'd1, 16'h0, 0);
      check("retained_mem1", bus_a.mem_value_o, 16'h5678);

      // reset in the middle of DUMP
      cpu_cycle(0, 0, 0, 0, 8'd0, 16'h0, 1);
      bus_a.end_program_i = 1'b0;
      cyc = 0;
      while (!bus_a.dump_valid_o && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      check("mid_dump_valid", bus_a.dump_valid_o, 1);
      rst_a = 1'b0;
      #1;
      check("mid_rst_valid", bus_a.dump_valid_o, 0);
      check("mid_rst_cpu_rst", bus_a.cpu_rst_o, 0);
      check("mid_rst_load_ready", bus_a.load_ready_o, 1);
      check("mid_rst_state", bus_a.state_o, 0);
      @(negedge clk);
      rst_a = 1'b1;
      load_byte(0, 8'h34, 0);
      load_byte(0, 8'h12, 1);
      check("reboot_cpu_rst", bus_a.cpu_rst_o, 1);
      cpu_cycle(0, 1, 0, 1, 8'd0, 16'h0, 0);
      check("reboot_mem0", bus_a.mem_value_o, 16'h1234);
      cpu_cycle(0, 0, 0, 0, 8'd0, 16'h0, 0);

      // full-memory boot on the 4-word instance: 16 bytes offered, 8 taken
      acc = 0;
      for (int k = 0; k < 16; k++) begin
         if (bus_b.load_ready_o) acc++;
         if (k == 8) check("b_ready_after_full", bus_b.load_ready_o, 0);
         bus_b.load_valid_i = 1'b1;
         bus_b.load_data_i  = 8'(k + 1);
         @(negedge clk);
      end
      bus_b.load_valid_i = 1'b0;
      check("b_accepted", acc, 8);
      check("b_state_run", bus_b.state_o, 1);
      check("b_cpu_rst", bus_b.cpu_rst_o, 1);
      for (int w = 0; w < 4; w++) begin
         cpu_cycle(1, 1, 0, 1, 8'(w), 16'h0, 0);
         check("b_rd_word", bus_b.mem_value_o, {8'(2 * w + 2), 8'(2 * w + 1)});
      end

      // streaming dump, sink always ready
      cpu_cycle(1, 0, 0, 0, 8'd0, 16'h0, 1);
      bus_b.end_program_i = 1'b0;
      for (int k = 1; k <= 8; k++) exp_q.push_back(8'(k));
      bus_b.dump_ready_i = 1'b1;
      started = 0; cyc = 0;
      while (exp_q.size() > 0 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (started) check("b_stream_valid", bus_b.dump_valid_o, 1);
         if (bus_b.dump_valid_o) begin
            started = 1;
            check("b_byte", bus_b.dump_data_o, exp_q.pop_front());
         end
      end
      check("b_drained", exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
      bus_b.dump_ready_i = 1'b0;
      check("b_done", bus_b.done_o, 1);
      check("b_done_valid", bus_b.dump_valid_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
- Unified 16-bit program/data memory placed directly downstream of the cpu memory port; serves the cpu's mem_addr/mem_value/rd/wr traffic.
- Also handles program boot: fills memory from a byte stream while the cpu is held in reset, then releases the cpu.
- When the cpu raises end_program, streams a memory window back out as bytes for result checking.

Parameters:
- ADDR_WIDTH, 8, word address width; depth = 2**ADDR_WIDTH 16-bit words.
- DUMP_WORDS, 16, number of words streamed out in DUMP, starting at word 0; range 1..2**ADDR_WIDTH.

Ports:
- clk_i  in  1  single clock, all logic rising-edge.
- rst_i  in  1  asynchronous, active-low reset.
- load_data_i  in  8  boot byte stream, low byte of each word first.
- load_valid_i  in  1  load byte valid.
- load_last_i  in  1  qualifies the final load byte.
- load_ready_o  out  1  loader accepts a byte.
- cpu_rst_o  out  1  active-low reset to the cpu (0 = cpu held in reset).
- mem_addr_i  in  ADDR_WIDTH  cpu word address.
- mem_value_i  in  16  cpu write data.
- mem_enable_i  in  1  cpu access enable.
- mem_wr_en_i  in  1  cpu write strobe.
- mem_rd_en_i  in  1  cpu read strobe.
- mem_value_o  out  16  read data to the cpu.
- end_program_i  in  1  cpu end-of-program flag.
- dump_data_o  out  8  dump byte, low byte first.
- dump_valid_o  out  1  dump byte valid.
- dump_ready_i  in  1  dump sink ready.
- done_o  out  1  dump complete.

Behaviour:
- Reset values (rst_i low, asynchronous): state = LOAD, load_ready_o = 1, cpu_rst_o = 0, mem_value_o = 0, dump_valid_o = 0, dump_data_o = 0, done_o = 0, load address = 0, byte phase = low.
- Memory contents are not reset.
- FSM states: LOAD -> RUN -> DUMP -> DONE. DONE exits only via reset.

LOAD:
- load_ready_o = 1.
- On valid & ready, a low-phase byte is latched and the phase flips.
- On a high-phase byte, {byte, latched_low} is written to mem[addr], addr increments and the phase returns to low.
- load_last_i on a low-phase byte writes {8'h00, byte}.
- After the write that carries load_last_i, or the write to address 2**ADDR_WIDTH-1, the FSM goes to RUN and load_ready_o drops the next cycle. The address does not wrap; extra bytes are not accepted.
- cpu_rst_o = 0 throughout LOAD.
- Cpu port inputs are ignored in LOAD.

RUN:
- cpu_rst_o is registered and goes to 1 in the first RUN cycle.
- Write: mem_enable_i & mem_wr_en_i writes mem_value_i to mem[mem_addr_i] at the clock edge.
- Read: mem_enable_i & mem_rd_en_i registers mem[mem_addr_i] into mem_value_o with 1-cycle latency.
- Simultaneous read and write to the same address: the write happens and mem_value_o returns the old contents (read-before-write).
- mem_value_o holds its last value when no read is issued.
- Strobes without mem_enable_i are ignored.
- end_program_i sampled high: go to DUMP; cpu_rst_o = 0 from the next cycle; any access in that same cycle is still performed.

DUMP:
- Word pointer starts at 0.
- Each word is emitted as low byte then high byte.
- dump_valid_o = 1 with dump_data_o stable until dump_ready_i = 1 (valid/ready; valid never drops without a handshake).
- Memory read latency is hidden: the first dump_valid_o rises at most 2 cycles after entry; thereafter one byte per cycle while ready is held high.
- After the high byte of word DUMP_WORDS-1 is accepted: go to DONE.

DONE:
- done_o = 1, dump_valid_o = 0, cpu_rst_o = 0.
- All inputs are ignored.

Reset mid-operation:
- Any state returns to LOAD immediately and cpu_rst_o drops asynchronously.
- Memory is retained but reloaded by the next boot.

Test Plan:
- Load bytes 34,12,78,56 with last on 56 -> mem[0]=16'h1234, mem[1]=16'h5678; cpu_rst_o rises exactly one cycle after the last write; load_ready_o = 0 afterwards.
- Odd-length load 0xAB with last -> mem[0]=16'h00AB; FSM in RUN.
- RUN: write 16'hBEEF to addr 5, read addr 5 the next cycle -> mem_value_o = 16'hBEEF one cycle later. Same-cycle read+write of 16'h1111 to addr 5 -> mem_value_o = 16'hBEEF and mem[5] = 16'h1111.
- ADDR_WIDTH=2, load 8 words' worth of bytes with no last -> only 4 words written; load_ready_o drops after the 4th word and RUN is entered.
- end_program_i pulse with DUMP_WORDS=2, mem[0]=16'h1234, mem[1]=16'h5678, dump_ready_i toggling 1,0,1,1,0,1 -> bytes 34,12,78,56 in order, data stable while stalled, done_o = 1 after the last byte, cpu_rst_o = 0.
- Assert rst_i low mid-DUMP -> dump_valid_o = 0, cpu_rst_o = 0, load_ready_o = 1 immediately; a new boot succeeds.
